alu_serial_exec: RTL and testbench
==================================

Name: alu_serial_exec

Overview:
Multi-cycle execution unit that consumes the 4-bit alu_control code produced by the ALU control decoder and applies it to two operands. Operands are processed DIGIT_W bits per cycle, LSB first, with carry held across cycles. The result is returned over a valid/ready handshake. It sits in the execute stage as the area-reduced alternative to the single-cycle ALU, and produces the zero flag used for BEQ.

Parameters:
XLEN, 32, operand/result width
DIGIT_W, 8, bits processed per compute cycle; must divide XLEN; N = XLEN/DIGIT_W compute cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
alu_control  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1111 NOP
operand_a  input  XLEN  first operand
operand_b  input  XLEN  second operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  operation result
zero  output  1  result == 0
illegal  output  1  alu_control was not one of the six listed codes

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n. The block has one clock.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, carry=0, digit counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready, latch alu_control, operand_a and operand_b.
  - Compute codes go to BUSY with counter=0. Carry-in is 1 for SUB/SLT and 0 otherwise.
  - NOP or an unlisted code goes directly to DONE with result=0. illegal=1 only for an unlisted code.
- BUSY: in_ready=0. Each cycle processes digit k = counter (bits k*DIGIT_W upward).
  - AND/OR are bitwise.
  - ADD: a+b+carry.
  - SUB/SLT: a + ~b + carry.
  - Carry-out of the digit is registered for the next digit.
  - Counter increments; after digit N-1, go to DONE.
- SLT: on the final digit, lt = sign(a-b) XOR signed overflow. Signed overflow = (a[XLEN-1] != b[XLEN-1]) & (diff[XLEN-1] != a[XLEN-1]). Result = {XLEN-1 zeros, lt}. Intermediate digit writes to result are permitted, but the final value is the only one visible when out_valid=1.
- Arithmetic is modulo 2^XLEN. Final carry-out is discarded.
- DONE: out_valid=1. result, zero and illegal are stable and held while out_ready=0.
  - On out_valid & out_ready, go to IDLE. out_valid falls and in_ready rises on the next cycle; there is no same-cycle accept of a new request.
- Latency (handshake in cycle T):
  - Compute ops: out_valid first high in cycle T+N+1 (default T+5).
  - NOP/illegal: out_valid first high in cycle T+1.
- in_valid while not in IDLE is ignored, and inputs are not sampled.
- Operand inputs may change after the accept cycle without affecting the result.
- zero is derived from the final result and is meaningful only while out_valid=1.
- rst_n low mid-operation (BUSY or DONE): immediate abort; all outputs return to reset values; the in-flight result is lost.

Test Plan:
- ADD, a=0x7FFFFFFF, b=0x00000001 -> out_valid at T+5, result=0x80000000, zero=0, illegal=0.
- SUB, a=5, b=5 -> result=0x00000000, zero=1. SUB, a=0, b=1 -> result=0xFFFFFFFF; confirms carry/borrow propagates across all 4 digits.
- SLT:
  - a=0xFFFFFFFF, b=0x00000001 -> result=1.
  - a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow case).
  - a=0x80000000, b=0x7FFFFFFF -> result=1.
- AND/OR, a=0xF0F0_1234, b=0x0FF0_FFFF -> AND=0x00F0_1234, OR=0xFFF0_FFFF. Then alu_control=0011 -> out_valid at T+1, result=0, illegal=1. Then 1111 -> out_valid at T+1, result=0, illegal=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result, zero and out_valid stable, in_ready=0. Toggle in_valid and operands during BUSY -> no effect. Release out_ready -> in_ready=1 on the next cycle.
- Assert rst_n=0 in the 2nd BUSY cycle of an ADD -> out_valid=0, in_ready=1, result=0 asynchronously. After release, a new ADD 3+4 returns result=7.

Source files
------------

// File: rtl/alu_serial_exec_if.sv
// Request/response bundle of the serial ALU.
interface alu_serial_exec_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_serial_exec.sv
// Digit-serial execute unit: AND/OR/ADD/SUB/SLT over XLEN/DIGIT_W cycles, LSB first.
module alu_serial_exec #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DIGIT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_serial_exec_if.slave  bus
);
  localparam int unsigned N     = XLEN / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal_q, illegal_d;

  int unsigned       lsb;
  logic [DIGIT_W-1:0] a_dig, b_dig, b_eff;
  logic [DIGIT_W:0]   sum;
  logic               is_sub;
  logic               ovf;
  logic               lt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, digit datapath and result update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;

    lsb    = 32'(cnt_q) * DIGIT_W;
    a_dig  = a_q[lsb +: DIGIT_W];
    b_dig  = b_q[lsb +: DIGIT_W];
    is_sub = (op_q == OP_SUB) || (op_q == OP_SLT);
    b_eff  = is_sub ? ~b_dig : b_dig;
    sum    = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, carry_q};
    // On the final digit sum[DIGIT_W-1] is the MSB of a-b.
    ovf    = (a_q[XLEN-1] != b_q[XLEN-1]) && (sum[DIGIT_W-1] != a_q[XLEN-1]);
    lt     = sum[DIGIT_W-1] ^ ovf;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d      = bus.alu_control;
          a_d       = bus.operand_a;
          b_d       = bus.operand_b;
          cnt_d     = '0;
          carry_d   = (bus.alu_control == OP_SUB) || (bus.alu_control == OP_SLT);
          illegal_d = 1'b0;
          case (bus.alu_control)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: state_d = BUSY;
            OP_NOP: begin
              state_d  = DONE;
              result_d = '0;
            end
            default: begin
              state_d   = DONE;
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        case (op_q)
          OP_AND:  result_d[lsb +: DIGIT_W] = a_dig & b_dig;
          OP_OR:   result_d[lsb +: DIGIT_W] = a_dig | b_dig;
          default: result_d[lsb +: DIGIT_W] = sum[DIGIT_W-1:0];
        endcase
        carry_d = sum[DIGIT_W];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          if (op_q == OP_SLT) begin
            result_d    = '0;
            result_d[0] = lt;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_serial_exec.sv
// Scoreboard bench for alu_serial_exec.
module tb_alu_serial_exec;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  alu_serial_exec_if #(.XLEN(32)) bus ();

  alu_serial_exec #(.XLEN(32), .DIGIT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: measures accept-to-valid latency and checks each delivered result.
  int   t_acc = 0;
  int   lat = 0;
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) t_acc = cyc;
      if (bus.out_valid && !prev_ov) lat = cyc - t_acc;
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got result 0x%08h expected no output", bus.result);
        end else begin
          e = sb.pop_front();
          chk("result",  bus.result,        e.res);
          chk("zero",    32'(bus.zero),     32'(e.z));
          chk("illegal", 32'(bus.illegal),  32'(e.ill));
          chk("latency", 32'(lat),          32'(e.lat));
        end
      end
    end
  end

  task automatic wait_valid();
    int k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: out_valid=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic z, input logic ill, input int l);
    sb.push_back('{res: res, z: z, ill: ill, lat: l});
    bus.alu_control = op;
    bus.operand_a   = a;
    bus.operand_b   = b;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.operand_a   = $urandom;
    bus.operand_b   = $urandom;
    bus.alu_control = 4'($urandom);
    wait_valid();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_control = '0;
    bus.operand_a   = '0;
    bus.operand_b   = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    bus.result,         32'h0);
    chk("rst_zero",      32'(bus.zero),      32'd1);
    chk("rst_illegal",   32'(bus.illegal),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 5);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 5);
    issue(OP_SUB, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0, 5);
    issue(OP_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 5);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 5);
    issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 5);
    issue(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5);
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 5);
    issue(OP_OR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0, 5);
    issue(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1, 1);
    issue(OP_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b0, 1);

    // Backpressure, with in_valid/operands toggled while busy.
    bus.out_ready = 1'b0;
    sb.push_back('{res: 32'h2345_6789, z: 1'b0, ill: 1'b0, lat: 5});
    bus.alu_control = OP_ADD;
    bus.operand_a   = 32'h1234_5678;
    bus.operand_b   = 32'h1111_1111;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bus.alu_control = OP_SUB;
      bus.operand_a   = $urandom;
      bus.operand_b   = $urandom;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_result",    bus.result,         32'h2345_6789);
      chk("bp_zero",      32'(bus.zero),      32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_same_cycle_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Asynchronous abort in the second BUSY cycle.
    bus.alu_control = OP_ADD;
    bus.operand_a   = 32'hAAAA_AAAA;
    bus.operand_b   = 32'h5555_5555;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_result",    bus.result,         32'h0);
    chk("abort_zero",      32'(bus.zero),      32'd1);
    chk("abort_illegal",   32'(bus.illegal),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 5);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
